// File: rtl/branch_predictor_core.sv
// branch_predictor_core: bimodal 2-bit-counter branch predictor sequenced by latch/update/predict trigger pulses
// Ports:
//   clock, reset_n                         rising-edge clock, asynchronous active-low reset
//   latch_trigger, update_trigger,         one-hot phase pulses from the upstream sequencer
//   predict_trigger
//   pc_in, branch_valid_in                 new branch address and its validity, captured in the latch phase
//   outcome_in, outcome_valid_in           resolved direction of the pending branch, captured in the latch phase
//   prediction, prediction_valid           registered direction for the last predicted branch
//   mispredict                             one-cycle pulse after an update that found a misprediction
//   hit_count, miss_count                  saturating prediction statistics
//   protocol_error                         sticky flag, set when triggers overlap
module branch_predictor_core #(
    parameter int INDEX_BITS  = 4,
    parameter int PC_WIDTH    = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   latch_trigger,
    input  logic                   update_trigger,
    input  logic                   predict_trigger,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   branch_valid_in,
    input  logic                   outcome_in,
    input  logic                   outcome_valid_in,
    output logic                   prediction,
    output logic                   prediction_valid,
    output logic                   mispredict,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count,
    output logic                   protocol_error
);
    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0]            table_q [DEPTH];
    logic [INDEX_BITS-1:0] latched_index;
    logic                  latched_branch_valid;
    logic                  latched_outcome;
    logic                  latched_outcome_valid;
    logic                  pending;
    logic [INDEX_BITS-1:0] pending_index;
    logic                  pending_prediction;
    logic [1:0]            trigger_sum;
    logic                  collision;
    logic                  do_latch;
    logic                  do_update;
    logic                  do_predict;
    logic                  hit;
    logic [1:0]            current;
    logic [1:0]            trained;
    logic                  table_msb;

    // Only the word-aligned index bits of the address ever influence behaviour,
    // so the latched copy keeps just those; the rest are folded away here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_in[PC_WIDTH-1:INDEX_BITS+2], pc_in[1:0]};

    always_comb begin
        trigger_sum = 2'(latch_trigger) + 2'(update_trigger) + 2'(predict_trigger);
        collision   = trigger_sum > 2'd1;
        do_latch    = latch_trigger && !collision;
        do_update   = update_trigger && !collision && pending && latched_outcome_valid;
        do_predict  = predict_trigger && !collision;
        hit         = latched_outcome == pending_prediction;
        current     = table_q[pending_index];
        trained     = latched_outcome ? ((current == 2'd3) ? current : current + 2'd1)
                                      : ((current == 2'd0) ? current : current - 2'd1);
        table_msb   = table_q[latched_index][1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= 2'b01;
        end else if (do_update) begin
            table_q[pending_index] <= trained;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latched_index         <= '0;
            latched_branch_valid  <= 1'b0;
            latched_outcome       <= 1'b0;
            latched_outcome_valid <= 1'b0;
            pending               <= 1'b0;
            pending_index         <= '0;
            pending_prediction    <= 1'b0;
            prediction            <= 1'b0;
            prediction_valid      <= 1'b0;
            mispredict            <= 1'b0;
            hit_count             <= '0;
            miss_count            <= '0;
            protocol_error        <= 1'b0;
        end else begin
            mispredict     <= do_update && !hit;
            protocol_error <= protocol_error || collision;
            if (do_latch) begin
                latched_index         <= pc_in[INDEX_BITS+1:2];
                latched_branch_valid  <= branch_valid_in;
                latched_outcome       <= outcome_in;
                latched_outcome_valid <= outcome_valid_in;
            end
            if (do_update) begin
                pending <= 1'b0;
                if (hit) hit_count <= (&hit_count) ? hit_count : hit_count + COUNT_WIDTH'(1);
                else miss_count <= (&miss_count) ? miss_count : miss_count + COUNT_WIDTH'(1);
            end
            // An older branch still pending is silently replaced here.
            if (do_predict) begin
                prediction_valid <= latched_branch_valid;
                if (latched_branch_valid) begin
                    prediction         <= table_msb;
                    pending            <= 1'b1;
                    pending_index      <= latched_index;
                    pending_prediction <= table_msb;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_core.sv
// tb_branch_predictor_core: vector, corner-case and randomized checks of branch_predictor_core against a behavioural model
module tb_branch_predictor_core;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        latch_trigger = 1'b0;
    logic        update_trigger = 1'b0;
    logic        predict_trigger = 1'b0;
    logic [31:0] pc_in = '0;
    logic        branch_valid_in = 1'b0;
    logic        outcome_in = 1'b0;
    logic        outcome_valid_in = 1'b0;

    logic        pred_a, pv_a, mis_a, perr_a;
    logic [15:0] hit_a, miss_a;
    logic        pred_b, pv_b, mis_b, perr_b;
    logic [1:0]  hit_b, miss_b;

    branch_predictor_core u_dut (
        .clock(clock), .reset_n(reset_n),
        .latch_trigger(latch_trigger), .update_trigger(update_trigger), .predict_trigger(predict_trigger),
        .pc_in(pc_in), .branch_valid_in(branch_valid_in), .outcome_in(outcome_in), .outcome_valid_in(outcome_valid_in),
        .prediction(pred_a), .prediction_valid(pv_a), .mispredict(mis_a),
        .hit_count(hit_a), .miss_count(miss_a), .protocol_error(perr_a)
    );

    branch_predictor_core #(.COUNT_WIDTH(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n),
        .latch_trigger(latch_trigger), .update_trigger(update_trigger), .predict_trigger(predict_trigger),
        .pc_in(pc_in), .branch_valid_in(branch_valid_in), .outcome_in(outcome_in), .outcome_valid_in(outcome_valid_in),
        .prediction(pred_b), .prediction_valid(pv_b), .mispredict(mis_b),
        .hit_count(hit_b), .miss_count(miss_b), .protocol_error(perr_b)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int mis_pulses = 0;

    int m_tbl [16];
    int l_idx, m_pidx, m_hits, m_misses;
    bit l_bv, l_oc, l_ov, m_pend, m_ppred, m_pred, m_pv, m_mis, m_perr;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 1;
        l_idx = 0; l_bv = 0; l_oc = 0; l_ov = 0;
        m_pend = 0; m_pidx = 0; m_ppred = 0;
        m_pred = 0; m_pv = 0; m_mis = 0; m_perr = 0;
        m_hits = 0; m_misses = 0;
    endtask

    task automatic model_step();
        int n;
        n = int'(latch_trigger) + int'(update_trigger) + int'(predict_trigger);
        m_mis = 0;
        if (n > 1) m_perr = 1;
        else if (latch_trigger) begin
            l_idx = int'((pc_in >> 2) & 32'hF);
            l_bv = branch_valid_in; l_oc = outcome_in; l_ov = outcome_valid_in;
        end else if (update_trigger) begin
            if (m_pend && l_ov) begin
                m_tbl[m_pidx] = l_oc ? sat(m_tbl[m_pidx] + 1, 3) : ((m_tbl[m_pidx] > 0) ? m_tbl[m_pidx] - 1 : 0);
                if (l_oc == m_ppred) m_hits++;
                else begin m_misses++; m_mis = 1; end
                m_pend = 0;
            end
        end else if (predict_trigger) begin
            if (l_bv) begin
                m_pred = m_tbl[l_idx] >= 2; m_pv = 1;
                m_pend = 1; m_pidx = l_idx; m_ppred = m_pred;
            end else m_pv = 0;
        end
    endtask

    task automatic compare_all();
        chk("prediction", 32'(pred_a), 32'(m_pred));
        chk("prediction_valid", 32'(pv_a), 32'(m_pv));
        chk("mispredict", 32'(mis_a), 32'(m_mis));
        chk("hit_count", 32'(hit_a), 32'(sat(m_hits, 65535)));
        chk("miss_count", 32'(miss_a), 32'(sat(m_misses, 65535)));
        chk("protocol_error", 32'(perr_a), 32'(m_perr));
        chk("prediction_w2", 32'(pred_b), 32'(m_pred));
        chk("mispredict_w2", 32'(mis_b), 32'(m_mis));
        chk("hit_count_w2", 32'(hit_b), 32'(sat(m_hits, 3)));
        chk("miss_count_w2", 32'(miss_b), 32'(sat(m_misses, 3)));
        chk("protocol_error_w2", 32'(perr_b), 32'(m_perr));
    endtask

    // Called at a falling edge; drives one cycle, advances the model on the rising edge, checks at the next falling edge.
    task automatic cyc(input bit lt, input bit ut, input bit pt, input logic [31:0] p, input bit b, input bit o, input bit v);
        latch_trigger = lt; update_trigger = ut; predict_trigger = pt;
        pc_in = p; branch_valid_in = b; outcome_in = o; outcome_valid_in = v;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
        if (mis_a) mis_pulses++;
        latch_trigger = 0; update_trigger = 0; predict_trigger = 0;
    endtask

    task automatic frame(input logic [31:0] p, input bit b, input bit o, input bit v);
        cyc(1, 0, 0, p, b, o, v);
        cyc(0, 1, 0, p, b, o, v);
        cyc(0, 0, 1, p, b, o, v);
        cyc(0, 0, 0, p, b, o, v);
    endtask

    task automatic do_reset();
        reset_n = 0;
        model_reset();
        #1;
        compare_all();
        @(negedge clock);
        reset_n = 1;
    endtask

    typedef struct {
        bit          rst;
        logic [31:0] pc;
        bit          bv, oc, ov;
        bit          pred, pv;
        int          hit, miss;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // training to taken, then back down
        vecs[0]  = '{1, 32'h40, 1, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{0, 32'h40, 1, 1, 1, 1, 1, 0, 1};
        vecs[2]  = '{0, 32'h40, 1, 1, 1, 1, 1, 1, 1};
        vecs[3]  = '{0, 32'h40, 1, 1, 1, 1, 1, 2, 1};
        vecs[4]  = '{0, 32'h40, 1, 0, 1, 1, 1, 2, 2};
        vecs[5]  = '{0, 32'h40, 1, 0, 1, 0, 1, 2, 3};
        // aliasing of 0x04 / 0x44, 0x08 independent
        vecs[6]  = '{1, 32'h04, 1, 0, 0, 0, 1, 0, 0};
        vecs[7]  = '{0, 32'h44, 1, 1, 1, 1, 1, 0, 1};
        vecs[8]  = '{0, 32'h08, 1, 1, 1, 0, 1, 1, 1};
        vecs[9]  = '{0, 32'h04, 1, 0, 1, 1, 1, 2, 1};
        vecs[10] = '{0, 32'h08, 1, 1, 1, 0, 1, 3, 1};
        // outcome withheld for one frame
        vecs[11] = '{1, 32'h40, 1, 0, 0, 0, 1, 0, 0};
        vecs[12] = '{0, 32'h00, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 32'h40, 1, 1, 1, 1, 1, 0, 1};

        @(negedge clock);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) do_reset();
            frame(vecs[i].pc, vecs[i].bv, vecs[i].oc, vecs[i].ov);
            chk($sformatf("vec%0d_pred", i), 32'(pred_a), 32'(vecs[i].pred));
            chk($sformatf("vec%0d_pv", i), 32'(pv_a), 32'(vecs[i].pv));
            chk($sformatf("vec%0d_hit", i), 32'(hit_a), 32'(vecs[i].hit));
            chk($sformatf("vec%0d_miss", i), 32'(miss_a), 32'(vecs[i].miss));
            chk($sformatf("vec%0d_miss_w2", i), 32'(miss_b), 32'(sat(vecs[i].miss, 3)));
        end

        // reset mid-frame discards latched and pending state
        do_reset();
        frame(32'h40, 1, 0, 0);
        cyc(1, 0, 0, 32'h40, 1, 1, 1);
        do_reset();
        chk("midreset_pv", 32'(pv_a), 32'd0);
        cyc(0, 1, 0, 32'h40, 1, 1, 1);
        chk("midreset_no_update_miss", 32'(miss_a), 32'd0);
        cyc(0, 0, 1, 32'h40, 1, 1, 1);
        chk("midreset_predict_unlatched", 32'(pv_a), 32'd0);
        frame(32'h40, 1, 1, 1);
        chk("postreset_pred", 32'(pred_a), 32'd0);
        chk("postreset_pv", 32'(pv_a), 32'd1);
        chk("postreset_stats", 32'(hit_a + miss_a), 32'd0);

        // five consecutive mispredictions
        do_reset();
        mis_pulses = 0;
        frame(32'h40, 1, 0, 0);
        for (int k = 0; k < 5; k++) frame(32'h40, 1, (k % 2) == 0, 1);
        chk("mispredict_pulses", 32'(mis_pulses), 32'd5);
        chk("miss_sat_w2", 32'(miss_b), 32'd3);
        chk("miss_w16", 32'(miss_a), 32'd5);

        // trigger collision
        cyc(0, 1, 1, 32'h44, 1, 1, 1);
        chk("collision_perr", 32'(perr_a), 32'd1);
        chk("collision_pred_kept", 32'(pred_a), 32'd1);
        chk("collision_miss_kept", 32'(miss_a), 32'd5);
        frame(32'h40, 1, 1, 1);
        chk("perr_sticky", 32'(perr_a), 32'd1);
        do_reset();
        chk("perr_cleared", 32'(perr_a), 32'd0);

        // randomized frames and stray trigger patterns
        for (int it = 0; it < 400; it++) begin
            if (it % 100 == 99) do_reset();
            if ($urandom_range(0, 9) < 8)
                frame($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            else begin
                int t;
                t = int'($urandom_range(0, 7));
                cyc(t[0], t[1], t[2], $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
